// File: rtl/test_fifo_pkg.sv
// test_fifo_pkg: default geometry and shared types for the test_fifo_sync FIFO
//   DATA_WIDTH_DEF : default word width
//   DATA_DEPTH_DEF : default number of entries (2**ADDR_WIDTH_DEF)
//   ADDR_WIDTH_DEF : default array address width
//   data_t         : one stored word at the default width
//   ptr_t          : read/write pointer at the default width, including the wrap bit
package test_fifo_pkg;
    localparam int DATA_WIDTH_DEF = 8;
    localparam int ADDR_WIDTH_DEF = 3;
    localparam int DATA_DEPTH_DEF = 2 ** ADDR_WIDTH_DEF;
    typedef logic [DATA_WIDTH_DEF-1:0] data_t;
    typedef logic [ADDR_WIDTH_DEF:0]   ptr_t;
endpackage

// File: rtl/test_fifo_mem.sv
// test_fifo_mem: FIFO storage array with one write port and one registered read port
//   clk   : clock, all updates on the rising edge
//   rst_n : synchronous active-low reset, clears rdata only (array is not reset)
//   we    : write strobe, already qualified by the caller
//   waddr : write address
//   wdata : write data
//   re    : read strobe, already qualified by the caller
//   raddr : read address
//   rdata : registered read data, holds its value when re is low
module test_fifo_mem
    import test_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DATA_DEPTH = DATA_DEPTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);
    logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            rdata <= '0;
        else if (re)
            rdata <= mem[raddr];
    end
endmodule

// File: rtl/test_fifo_sync.sv
// test_fifo_sync: single-clock FIFO with registered read data and full/empty flags
//   clk   : clock, all state updates on the rising edge
//   rst_n : synchronous active-low reset, empties the FIFO and clears dout
//   w_en  : write request, accepted when !full
//   din   : write data, sampled with w_en
//   r_en  : read request, accepted when !empty
//   dout  : registered read data, holds the last popped word
//   full  : DATA_DEPTH entries stored
//   empty : no entries stored
//   count : occupancy 0..DATA_DEPTH, present only when TEST_FIFO_COUNT_EN is defined
module test_fifo_sync
    import test_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DATA_DEPTH = DATA_DEPTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  w_en,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  r_en,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  full,
    output logic                  empty
`ifdef TEST_FIFO_COUNT_EN
    ,
    output logic [ADDR_WIDTH:0]   count
`endif
);
    logic [ADDR_WIDTH:0] wptr, rptr;
    logic                push, pop;

    // The extra MSB on each pointer tells full (one lap apart) from empty (same lap).
    assign empty = (wptr == rptr);
    assign full  = (wptr[ADDR_WIDTH] != rptr[ADDR_WIDTH]) &&
                   (wptr[ADDR_WIDTH-1:0] == rptr[ADDR_WIDTH-1:0]);

    // Both requests are judged against the pre-edge flags; reset masks them so a
    // pending request in the reset cycle cannot touch memory or dout.
    assign push = rst_n && w_en && !full;
    assign pop  = rst_n && r_en && !empty;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push)
                wptr <= wptr + 1'b1;
            if (pop)
                rptr <= rptr + 1'b1;
        end
    end

`ifdef TEST_FIFO_COUNT_EN
    assign count = wptr - rptr;
`endif

    test_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DATA_DEPTH (DATA_DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (push),
        .waddr (wptr[ADDR_WIDTH-1:0]),
        .wdata (din),
        .re    (pop),
        .raddr (rptr[ADDR_WIDTH-1:0]),
        .rdata (dout)
    );
endmodule

// File: tb/tb_test_fifo_sync.sv
// tb_test_fifo_sync: scoreboard bench for test_fifo_sync
module tb_test_fifo_sync;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       w_en = 1'b0;
    logic [7:0] din = '0;
    logic       r_en = 1'b0;
    logic [7:0] dout;
    logic       full, empty;
`ifdef TEST_FIFO_COUNT_EN
    logic [3:0] count;
`endif

    int n_vec = 0;
    int n_err = 0;
    logic [7:0] model [$];
    logic [7:0] exp_q [$];
    logic [7:0] last_dout = '0;

    test_fifo_sync dut (
        .clk   (clk),
        .rst_n (rst_n),
        .w_en  (w_en),
        .din   (din),
        .r_en  (r_en),
        .dout  (dout),
        .full  (full),
        .empty (empty)
`ifdef TEST_FIFO_COUNT_EN
        ,
        .count (count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_state();
        chk("dout", 32'(dout), 32'(last_dout));
        chk("empty", 32'(empty), 32'(model.size() == 0));
        chk("full", 32'(full), 32'(model.size() == 8));
`ifdef TEST_FIFO_COUNT_EN
        chk("count", 32'(count), 32'(model.size()));
`endif
    endtask

    task automatic cycle(input logic w, input logic [7:0] d, input logic r);
        bit do_push;
        bit do_pop;
        do_push = w && (model.size() < 8);
        do_pop  = r && (model.size() > 0);
        w_en = w;
        din  = d;
        r_en = r;
        if (do_pop)
            exp_q.push_back(model.pop_front());
        if (do_push)
            model.push_back(d);
        @(posedge clk);
        #1;
        if (do_pop)
            last_dout = exp_q.pop_front();
        chk_state();
        w_en = 1'b0;
        r_en = 1'b0;
    endtask

    task automatic do_reset(input logic w, input logic r);
        rst_n = 1'b0;
        w_en  = w;
        din   = 8'hEE;
        r_en  = r;
        @(posedge clk);
        #1;
        model.delete();
        exp_q.delete();
        last_dout = '0;
        chk_state();
        rst_n = 1'b1;
        w_en  = 1'b0;
        r_en  = 1'b0;
    endtask

    initial begin
        do_reset(1'b0, 1'b0);
        for (int i = 1; i <= 10; i++) cycle(1'b1, 8'(i), 1'b0);
        for (int i = 0; i < 10; i++) cycle(1'b0, 8'h00, 1'b1);
        for (int i = 99; i <= 102; i++) cycle(1'b1, 8'(i), 1'b0);
        cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b1, 8'd7, 1'b0);
        cycle(1'b1, 8'd8, 1'b0);
        cycle(1'b1, 8'd55, 1'b1);
        for (int i = 0; i < 5; i++) cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b1, 8'd55, 1'b1);
        cycle(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 8; i++) cycle(1'b1, 8'(200 + i), 1'b0);
        cycle(1'b1, 8'd77, 1'b1);
        for (int i = 0; i < 8; i++) cycle(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'(30 + i), 1'b0);
        do_reset(1'b1, 1'b1);
        cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b1, 8'd66, 1'b0);
        cycle(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 300; i++)
            cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/test_fifo_sync.md
# test_fifo_sync

Single-clock, synchronous first-in/first-out buffer, 8 entries × 8 bits by default, with registered read data and full/empty status. Sits between a producer and a consumer sharing one clock domain; the producer pushes with `w_en` while not `full`, and the consumer pops with `r_en` while not `empty`. Writes to a full FIFO and reads from an empty FIFO are ignored without corrupting state.

## Interface
- `DATA_WIDTH`, 8: width of each stored word.
- `DATA_DEPTH`, 8: number of entries; must equal 2**`ADDR_WIDTH`.
- `ADDR_WIDTH`, 3: memory address width.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `w_en`  in  1  write request; data accepted when `w_en && !full` at a rising `clk`.
- `din`  in  `DATA_WIDTH`  write data, sampled with `w_en`.
- `r_en`  in  1  read request; pop performed when `r_en && !empty` at a rising `clk`.
- `dout`  out  `DATA_WIDTH`  registered read data.
- `full`  out  1  high when `DATA_DEPTH` entries are stored.
- `empty`  out  1  high when 0 entries are stored.

## Operation
- Storage: `DATA_DEPTH`-entry register array.
- Pointers: write and read pointers are each `ADDR_WIDTH`+1 bits wide. The low bits address the array, and the MSB is a wrap bit.
- Status decode:
  - `empty` = (wptr == rptr).
  - `full` = (MSBs differ && low bits equal).
  - Both are combinational from the registered pointers.
- Write: when `w_en && !full`, store `din` at wptr, then wptr+1. When `w_en && full`, the write is dropped; pointers and memory are unchanged.
- Read: when `r_en && !empty`, load `dout` with mem[rptr], then rptr+1. When `r_en && empty`, the read is dropped and `dout` holds its value.
- `dout` holds its last popped value whenever no pop occurs.
- Simultaneous `w_en` and `r_en`:
  - Each operation is qualified independently against the pre-edge flags.
  - Full + both: only the read executes.
  - Empty + both: only the write executes. There is no fall-through, so the new word is not visible on `dout` that cycle.
  - Otherwise both execute and occupancy is unchanged.
- Wrap-around: pointer arithmetic is modulo 2**(`ADDR_WIDTH`+1). Array index is the pointer modulo `DATA_DEPTH`.

## Timing
- Reset (`rst_n` low at a rising `clk`): wptr=0, rptr=0, `dout`=0, so `empty`=1 and `full`=0. Memory contents are not reset.
- Reset asserted mid-operation discards all stored data at that edge. Any pending `w_en`/`r_en` in that cycle is ignored.
- Write latency: a word written at edge N is poppable at edge N+1, because `empty` deasserts after edge N.
- Read latency: the pop at edge N presents data on `dout` immediately after edge N. `dout` is stable for sampling any time before edge N+1.
- `full` asserts right after the 8th un-popped write edge. It deasserts right after the next pop edge.
- Throughput: one push and one pop per cycle.

## Configuration
- `TEST_FIFO_COUNT_EN` defined:
  - Adds output port `count` [`ADDR_WIDTH`:0] = wptr − rptr (mod 2**(`ADDR_WIDTH`+1)), range 0..`DATA_DEPTH`.
  - `count` reset value is 0.
- `TEST_FIFO_COUNT_EN` undefined: no `count` port and no subtraction logic. All other behaviour is identical.

## Structure
- Package `test_fifo_pkg`:
  - Default constants for `DATA_WIDTH`, `DATA_DEPTH`, `ADDR_WIDTH`.
  - Typedefs `data_t` (`DATA_WIDTH` bits) and `ptr_t` (`ADDR_WIDTH`+1 bits).
- One sub-module, `test_fifo_mem`: the register array with one write port and one registered read port. The top holds pointers, flags and the enable qualification.

## Test plan
- Reset: drive `rst_n`=0 for one edge → `empty`=1, `full`=0, `dout`=0.
- Fill past capacity: push 1..10 on consecutive cycles → 1..8 accepted; `full`=1 after the 8th push; pushes 9 and 10 dropped.
- Drain past empty: pop 10 times → `dout` reads 1..8 in order; `empty`=1 after the 8th pop; pops 9 and 10 leave `dout`=8.
- Wrap-around: push 99, 100, 101, 102, then pop twice → `dout`=99 then 100; `empty`=0.
- Simultaneous push/pop:
  - With 4 entries: push 55 while popping → occupancy stays 4.
  - On empty: push+pop → only 55 stored; `dout` unchanged.
  - On full: push+pop → push dropped; oldest word popped.
- Mid-operation reset: load 3 words, assert `rst_n`=0 → `empty`=1. A following pop is ignored, and a new push/pop returns the new word.
